// File: rtl/cpu_hazard_pkg.sv
// cpu_hazard_pkg: shared FSM state and forwarding-select types for the hazard controller
package cpu_hazard_pkg;
  localparam int FWD_SEL_W = 2;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH_APPLY} hz_state_t;
  typedef enum logic [FWD_SEL_W-1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_t;
endpackage

// File: rtl/cpu_forward_unit.sv
// cpu_forward_unit: operand bypass select for one execute-stage source
// Ports: i_src/i_use describe the operand; i_mem_*/i_wb_* describe the two producer stages;
// o_sel picks register file, EX/MEM or MEM/WB (youngest producer wins).
module cpu_forward_unit
  import cpu_hazard_pkg::*;
#(
  parameter int REG_ID_W       = 5,
  parameter int ZERO_REG_FIXED = 1
) (
  input  logic [REG_ID_W-1:0]  i_src,
  input  logic                 i_use,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_reg_write,
  input  logic [REG_ID_W-1:0]  i_mem_reg_dest,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_reg_write,
  input  logic [REG_ID_W-1:0]  i_wb_reg_dest,
  output logic [FWD_SEL_W-1:0] o_sel
);
  logic w_zero, w_mem_hit, w_wb_hit;
  always_comb begin
    w_zero    = (ZERO_REG_FIXED != 0) && (i_src == '0);
    w_mem_hit = i_mem_valid & i_mem_reg_write & (i_mem_reg_dest == i_src);
    w_wb_hit  = i_wb_valid & i_wb_reg_write & (i_wb_reg_dest == i_src);
    o_sel     = (!i_use || w_zero) ? FWD_RF : w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/cpu_hazard_ctrl.sv
// cpu_hazard_ctrl: pipeline interlock controller (stall, bubble, flush, forwarding, perf counters)
// Ports: id_*/ex_*/mem_*/wb_* describe the instructions in each stage; branch_taken and dmem_busy
// drive the wait/squash sequencing; pipe_freeze/pc_stall/ifid_stall/idex_bubble/flush_* steer the
// pipeline registers; fwd_a/fwd_b select execute operands; perf_* count stalled and flushed cycles.
module cpu_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int REG_ID_W       = 5,
  parameter int ZERO_REG_FIXED = 1,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_ID_W-1:0] id_ra_id,
  input  logic [REG_ID_W-1:0] id_rb_id,
  input  logic                id_use_reg_b,
  input  logic                ex_valid,
  input  logic [REG_ID_W-1:0] ex_ra_id,
  input  logic [REG_ID_W-1:0] ex_rb_id,
  input  logic                ex_use_reg_b,
  input  logic [REG_ID_W-1:0] ex_reg_dest,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                mem_valid,
  input  logic [REG_ID_W-1:0] mem_reg_dest,
  input  logic                mem_reg_write,
  input  logic                wb_valid,
  input  logic [REG_ID_W-1:0] wb_reg_dest,
  input  logic                wb_reg_write,
  input  logic                branch_taken,
  input  logic                dmem_busy,
  output logic                pipe_freeze,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                idex_bubble,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic                flush_exmem,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_W-1:0]    perf_stall_cnt,
  output logic [CNT_W-1:0]    perf_flush_cnt
);
  hz_state_t r_state, w_next;
  logic r_pend, w_pend_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_load_use, w_freeze, w_lu, w_flush;
  logic [FWD_SEL_W-1:0] w_fwd_a, w_fwd_b;

  cpu_forward_unit #(.REG_ID_W(REG_ID_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_fwd_a (
    .i_src(ex_ra_id), .i_use(1'b1),
    .i_mem_valid(mem_valid), .i_mem_reg_write(mem_reg_write), .i_mem_reg_dest(mem_reg_dest),
    .i_wb_valid(wb_valid), .i_wb_reg_write(wb_reg_write), .i_wb_reg_dest(wb_reg_dest),
    .o_sel(w_fwd_a)
  );

  cpu_forward_unit #(.REG_ID_W(REG_ID_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_fwd_b (
    .i_src(ex_rb_id), .i_use(ex_use_reg_b),
    .i_mem_valid(mem_valid), .i_mem_reg_write(mem_reg_write), .i_mem_reg_dest(mem_reg_dest),
    .i_wb_valid(wb_valid), .i_wb_reg_write(wb_reg_write), .i_wb_reg_dest(wb_reg_dest),
    .o_sel(w_fwd_b)
  );

  always_comb begin
    w_load_use = ex_valid & ex_mem_read & ex_reg_write & id_valid &
                 !((ZERO_REG_FIXED != 0) && (ex_reg_dest == '0)) &
                 ((ex_reg_dest == id_ra_id) | (id_use_reg_b & (ex_reg_dest == id_rb_id)));
  end

  // A branch seen while memory is busy is remembered in r_pend and replayed
  // as a dedicated flush cycle once the wait ends.
  always_comb begin
    w_next      = r_state;
    w_pend_next = r_pend;
    w_freeze    = 1'b0;
    w_lu        = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      RUN: begin
        if (dmem_busy) begin
          w_freeze    = 1'b1;
          w_next      = MEM_WAIT;
          w_pend_next = r_pend | branch_taken;
        end else if (branch_taken) w_flush = 1'b1;
        else w_lu = w_load_use;
      end
      MEM_WAIT: begin
        w_pend_next = r_pend | branch_taken;
        if (dmem_busy) w_freeze = 1'b1;
        else if (r_pend | branch_taken) w_next = FLUSH_APPLY;
        else begin
          w_next = RUN;
          w_lu   = w_load_use;
        end
      end
      FLUSH_APPLY: begin
        w_flush     = 1'b1;
        w_pend_next = 1'b0;
        w_next      = dmem_busy ? MEM_WAIT : RUN;
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pend      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_pend      <= w_pend_next;
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_freeze | w_lu};
      r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_flush};
    end
  end

  // Outputs are forced low while reset is held, even if inputs are active.
  always_comb begin
    pipe_freeze    = rst_n & w_freeze;
    pc_stall       = rst_n & (w_freeze | w_lu);
    ifid_stall     = rst_n & (w_freeze | w_lu);
    idex_bubble    = rst_n & w_lu;
    flush_ifid     = rst_n & w_flush;
    flush_idex     = rst_n & w_flush;
    flush_exmem    = rst_n & w_flush;
    fwd_a          = rst_n ? w_fwd_a : 2'd0;
    fwd_b          = rst_n ? w_fwd_b : 2'd0;
    perf_stall_cnt = r_stall_cnt;
    perf_flush_cnt = r_flush_cnt;
  end
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// tb_cpu_hazard_ctrl: scoreboard-driven bench for the hazard controller
module tb_cpu_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_use_reg_b, ex_valid, ex_use_reg_b, ex_reg_write, ex_mem_read;
  logic mem_valid, mem_reg_write, wb_valid, wb_reg_write, branch_taken, dmem_busy;
  logic [4:0] id_ra_id, id_rb_id, ex_ra_id, ex_rb_id, ex_reg_dest, mem_reg_dest, wb_reg_dest;
  logic pipe_freeze, pc_stall, ifid_stall, idex_bubble, flush_ifid, flush_idex, flush_exmem;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  cpu_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ra_id(id_ra_id), .id_rb_id(id_rb_id), .id_use_reg_b(id_use_reg_b),
    .ex_valid(ex_valid), .ex_ra_id(ex_ra_id), .ex_rb_id(ex_rb_id), .ex_use_reg_b(ex_use_reg_b),
    .ex_reg_dest(ex_reg_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_valid(mem_valid), .mem_reg_dest(mem_reg_dest), .mem_reg_write(mem_reg_write),
    .wb_valid(wb_valid), .wb_reg_dest(wb_reg_dest), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pipe_freeze(pipe_freeze), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // {freeze, pc_stall, ifid_stall, bubble, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b}
  logic [10:0] obs;
  assign obs = {pipe_freeze, pc_stall, ifid_stall, idex_bubble,
                flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b};

  localparam logic [6:0] K_NONE = 7'b0000000;
  localparam logic [6:0] K_FRZ  = 7'b1110000;
  localparam logic [6:0] K_LU   = 7'b0111000;
  localparam logic [6:0] K_FL   = 7'b0000111;

  typedef struct {
    string       name;
    logic [10:0] v;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic mv, mw; logic [4:0] md;
    logic wv, ww; logic [4:0] wd, ra, rb;
    logic ub; logic [1:0] fa, fb;
  } fwd_row_t;

  task automatic idle();
    id_valid = 0; id_ra_id = 0; id_rb_id = 0; id_use_reg_b = 0;
    ex_valid = 0; ex_ra_id = 0; ex_rb_id = 0; ex_use_reg_b = 0;
    ex_reg_dest = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_valid = 0; mem_reg_dest = 0; mem_reg_write = 0;
    wb_valid = 0; wb_reg_dest = 0; wb_reg_write = 0;
    branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic push(input string name, input logic [6:0] c, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.name = name;
    e.v = {c, fa, fb};
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    branch_taken = 1; dmem_busy = 1; mem_valid = 1; mem_reg_write = 1; mem_reg_dest = 7; ex_ra_id = 7;
    push("reset_outputs", K_NONE, 2'd0, 2'd0);
    #2;
    e = sb.pop_front();
    total++;
    if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
    total++;
    if (perf_stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", perf_stall_cnt); else passed++;
    total++;
    if (perf_flush_cnt !== 32'd0) $display("FAIL reset_flush_cnt: got %0d expected 0", perf_flush_cnt); else passed++;
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [6:0] xc[7] = '{K_LU, K_NONE, K_NONE, K_NONE, K_LU, K_NONE, K_NONE};
    logic [1:0] xa[7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle();
      case (i)
        0: begin
          id_valid = 1; id_ra_id = 3;
          ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_reg_dest = 3;
        end
        1: begin
          ex_valid = 1; ex_ra_id = 3; ex_reg_write = 1; ex_reg_dest = 4;
          mem_valid = 1; mem_reg_write = 1; mem_reg_dest = 3;
        end
        3: begin
          id_valid = 1; id_ra_id = 0; id_rb_id = 0; id_use_reg_b = 1;
          ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_reg_dest = 0;
        end
        4, 5: begin
          id_valid = 1; id_ra_id = 1; id_rb_id = 3; id_use_reg_b = (i == 4);
          ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_reg_dest = 3;
        end
        default: ;
      endcase
      push($sformatf("load_use_c%0d", i), xc[i], xa[i], 2'd0);
      #2;
      e = sb.pop_front();
      total++;
      if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
      if (i == 2 || i == 6) begin
        total++;
        if (perf_stall_cnt !== ((i == 2) ? 32'd1 : 32'd2))
          $display("FAIL load_use_stall_cnt_c%0d: got %0d expected %0d", i, perf_stall_cnt, (i == 2) ? 1 : 2);
        else passed++;
      end
    end
  endtask

  task automatic test_forward();
    exp_t e;
    fwd_row_t rows[6] = '{
      '{1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 2'd1, 2'd1},
      '{1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 2'd2, 2'd2},
      '{1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 2'd0},
      '{1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 2'd2, 2'd0},
      '{1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd9, 5'd7, 5'd9, 1'b1, 2'd0, 2'd2},
      '{1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 5'd3, 5'd6, 1'b1, 2'd0, 2'd0}
    };
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      ex_valid = 1;
      mem_valid = rows[i].mv; mem_reg_write = rows[i].mw; mem_reg_dest = rows[i].md;
      wb_valid = rows[i].wv; wb_reg_write = rows[i].ww; wb_reg_dest = rows[i].wd;
      ex_ra_id = rows[i].ra; ex_rb_id = rows[i].rb; ex_use_reg_b = rows[i].ub;
      push($sformatf("forward_row%0d", i), K_NONE, rows[i].fa, rows[i].fb);
      #2;
      e = sb.pop_front();
      total++;
      if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
    end
  endtask

  // Runs a busy/branch sequence with per-cycle expected controls, then checks both counters.
  task automatic test_sequence(input string tag, input logic bz[], input logic br[],
                               input logic [6:0] xc[], input logic [31:0] exp_stall,
                               input logic [31:0] exp_flush, input logic with_load_use);
    exp_t e;
    apply_reset();
    for (int i = 0; i < bz.size(); i++) begin
      @(negedge clk);
      idle();
      dmem_busy = bz[i];
      branch_taken = br[i];
      if (with_load_use) begin
        id_valid = 1; id_ra_id = 2;
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_reg_dest = 2;
      end
      push($sformatf("%s_c%0d", tag, i), xc[i], 2'd0, 2'd0);
      #2;
      e = sb.pop_front();
      total++;
      if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
    end
    @(negedge clk);
    idle();
    #2;
    total++;
    if (perf_stall_cnt !== exp_stall) $display("FAIL %s_stall_cnt: got %0d expected %0d", tag, perf_stall_cnt, exp_stall); else passed++;
    total++;
    if (perf_flush_cnt !== exp_flush) $display("FAIL %s_flush_cnt: got %0d expected %0d", tag, perf_flush_cnt, exp_flush); else passed++;
  endtask

  task automatic test_branch();
    logic bz[] = '{1'b0, 1'b0};
    logic br[] = '{1'b1, 1'b0};
    logic [6:0] xc[] = '{K_FL, K_NONE};
    test_sequence("branch", bz, br, xc, 32'd0, 32'd1, 1'b0);
  endtask

  task automatic test_mem_wait();
    logic bz[] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic br[] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0] xc[] = '{K_FRZ, K_FRZ, K_FRZ, K_FRZ, K_NONE, K_FL, K_NONE};
    test_sequence("mem_wait", bz, br, xc, 32'd4, 32'd1, 1'b0);
  endtask

  task automatic test_same_cycle();
    logic bz[] = '{1'b0};
    logic br[] = '{1'b1};
    logic [6:0] xc[] = '{K_FL};
    test_sequence("lu_and_branch", bz, br, xc, 32'd0, 32'd1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic bz[] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic br[] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0] xc[] = '{K_FRZ, K_NONE, K_FL, K_FRZ, K_NONE, K_NONE};
    test_sequence("flush_into_busy", bz, br, xc, 32'd2, 32'd1, 1'b0);
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [6:0] xc[6] = '{K_FRZ, K_FRZ, K_NONE, K_NONE, K_NONE, K_FL};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      if (i < 2) dmem_busy = 1;
      if (i == 0) branch_taken = 1;
      if (i == 2) rst_n = 1;
      if (i == 5) branch_taken = 1;
      push($sformatf("async_c%0d", i), xc[i], 2'd0, 2'd0);
      #2;
      e = sb.pop_front();
      total++;
      if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
      if (i == 1) begin
        #1 rst_n = 0;
        push("async_drop", K_NONE, 2'd0, 2'd0);
        #1;
        e = sb.pop_front();
        total++;
        if (obs !== e.v) $display("FAIL %s: got %b expected %b", e.name, obs, e.v); else passed++;
        total++;
        if (perf_stall_cnt !== 32'd0) $display("FAIL async_drop_stall_cnt: got %0d expected 0", perf_stall_cnt); else passed++;
      end
    end
    @(negedge clk);
    idle();
    #2;
    total++;
    if (perf_stall_cnt !== 32'd0) $display("FAIL async_after_stall_cnt: got %0d expected 0", perf_stall_cnt); else passed++;
    total++;
    if (perf_flush_cnt !== 32'd1) $display("FAIL async_after_flush_cnt: got %0d expected 1", perf_flush_cnt); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
Pipeline interlock controller for the decode→execute→commit→writeback pipeline.
- Generates stall, bubble and flush controls for the pipeline registers.
- Generates operand forwarding selects for the instruction held in the ID/EX (execute) register.
- Sequences data-memory wait states and taken-branch squashes; a branch that arrives during a memory wait is deferred until the wait ends.
- Keeps stall and flush performance counters.

Parameters:
REG_ID_W, 5, register id width (clog2 of NUM_REGS)
ZERO_REG_FIXED, 1, 1 means register 0 is never a hazard source and never forwarded
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_ra_id  in  REG_ID_W  decode source A
id_rb_id  in  REG_ID_W  decode source B
id_use_reg_b  in  1  decode instruction reads source B
ex_valid  in  1  ID/EX register valid
ex_ra_id  in  REG_ID_W  execute source A
ex_rb_id  in  REG_ID_W  execute source B
ex_use_reg_b  in  1  execute instruction reads source B
ex_reg_dest  in  REG_ID_W  execute destination
ex_reg_write  in  1  execute instruction writes a register
ex_mem_read  in  1  execute instruction is a load
mem_valid  in  1  EX/MEM register valid
mem_reg_dest  in  REG_ID_W  commit-stage destination
mem_reg_write  in  1  commit-stage writes a register
wb_valid  in  1  MEM/WB register valid
wb_reg_dest  in  REG_ID_W  writeback destination
wb_reg_write  in  1  writeback writes a register
branch_taken  in  1  commit stage resolved a taken branch (one-cycle pulse)
dmem_busy  in  1  data memory has not completed its access
pipe_freeze  out  1  all pipeline registers and PC hold
pc_stall  out  1  PC holds
ifid_stall  out  1  IF/ID register holds
idex_bubble  out  1  ID/EX register loads a NOP (valid=0)
flush_ifid  out  1  IF/ID register clears
flush_idex  out  1  ID/EX register clears
flush_exmem  out  1  EX/MEM register clears
fwd_a  out  2  source A select: 0 register file, 1 EX/MEM, 2 MEM/WB
fwd_b  out  2  source B select, same encoding
perf_stall_cnt  out  CNT_W  number of stalled or frozen cycles
perf_flush_cnt  out  CNT_W  number of flushes applied

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to RUN.
  - pending_flush = 0 and both counters = 0.
  - All control outputs are 0 and fwd_a = fwd_b = 0 while rst_n is low.
- FSM states are RUN, MEM_WAIT and FLUSH_APPLY.
- RUN:
  - If dmem_busy: pipe_freeze = pc_stall = ifid_stall = 1 this cycle. Next state is MEM_WAIT. If branch_taken is also high, set pending_flush.
  - Else if branch_taken: flush_ifid = flush_idex = flush_exmem = 1 this cycle. pc_stall = 0, because the PC loads the branch target. Stay in RUN.
  - Else if load-use: pc_stall = ifid_stall = idex_bubble = 1 for exactly this cycle. The condition is ex_valid & ex_mem_read & ex_reg_write & id_valid & (ex_reg_dest == id_ra_id | (id_use_reg_b & ex_reg_dest == id_rb_id)). The hazard resolves naturally next cycle.
- MEM_WAIT:
  - Freeze outputs stay asserted while dmem_busy is high.
  - A branch_taken pulse in this state sets pending_flush.
  - When dmem_busy falls: if pending_flush, go to FLUSH_APPLY; else go to RUN with no freeze this cycle.
- FLUSH_APPLY:
  - Lasts one cycle: the three flushes are asserted and pending_flush is cleared.
  - Next state is RUN. If dmem_busy is already high again, go to MEM_WAIT; the flush still applies in this cycle.
- Priority within one cycle: freeze > branch flush > load-use stall. A flush suppresses idex_bubble.
- Forwarding is combinational. For source A (B is identical, and is gated by ex_use_reg_b):
  - Select 1 if mem_valid & mem_reg_write & mem_reg_dest == ex_ra_id.
  - Else select 2 if wb_valid & wb_reg_write & wb_reg_dest == ex_ra_id.
  - Else select 0.
  - When ZERO_REG_FIXED is set, source id 0 always selects 0.
- Register 0 never triggers a load-use stall when ZERO_REG_FIXED is set.
- Counters:
  - perf_stall_cnt increments on every cycle with pipe_freeze or a load-use stall.
  - perf_flush_cnt increments on every cycle in which the flushes are asserted.
  - Both counters wrap modulo 2^CNT_W.

Decomposition:
- Package cpu_hazard_pkg holds:
  - hz_state_t enum {RUN, MEM_WAIT, FLUSH_APPLY}.
  - fwd_sel_t enum {FWD_RF=0, FWD_MEM=1, FWD_WB=2}.
  - Select-width constant.
- Sub-module cpu_forward_unit: purely combinational, instantiated once per operand.

Test Plan:
- Load r3 in EX while decode reads r3 on A → exactly 1 cycle of pc_stall/ifid_stall/idex_bubble; the next cycle has fwd_a=1 for the EX instruction; perf_stall_cnt=1.
- EX reads r5, EX/MEM and MEM/WB both write r5 → fwd_a=1. With only MEM/WB writing r5 → fwd_a=2. Source r0 with both stages writing r0 → fwd_a=0.
- branch_taken pulse in RUN → the three flushes high for 1 cycle, pc_stall=0; perf_flush_cnt=1.
- dmem_busy high for 4 cycles with branch_taken on wait cycle 2 → pipe_freeze for 4 cycles, then FLUSH_APPLY for 1 cycle with flushes; perf_stall_cnt=4, perf_flush_cnt=1.
- Load-use and branch_taken in the same cycle → flushes asserted, idex_bubble=0, no stall counted.
- rst_n dropped asynchronously mid-MEM_WAIT with pending_flush set → outputs 0 immediately. After release: state RUN, no flush, counters 0.
